// File: rtl/risc_pkg.sv
// Shared definitions for the Simple-RISC datapath blocks: timer state
// encoding and the default counter width used by the counting blocks.
package risc_pkg;

    // Default counter width shared by countdown_timer and counterNbits
    localparam int CNT_W = 5;

    // Timer control states; encoding is fixed so other blocks can decode it
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } timer_state_t;

    // True in the states where the timer owns the count (RUN and DONE)
    function automatic logic state_is_busy(input timer_state_t s);
        return (s == RUN) || (s == DONE);
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/busy/done handshake and optional
// auto-reload. Counts from a preset to zero, then spends exactly one cycle
// in DONE (done pulse) before idling or reloading. All outputs registered.
module countdown_timer
    import risc_pkg::*;
#(
    parameter int N = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         load,
    input  logic         abort,
    input  logic         en,
    input  logic         auto_reload,
    input  logic [N-1:0] preset,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = N'(1);

    timer_state_t state;
    timer_state_t next_state;
    logic [N-1:0] rld;
    logic [N-1:0] out_nxt;
    logic [N-1:0] rld_nxt;
    logic         preset_zero;
    logic         rld_zero;
    logic         out_le_one;

    assign preset_zero = (preset == ZERO);
    assign rld_zero    = (rld == ZERO);
    assign out_le_one  = (out <= ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and next count/reload values, priority abort > load > start > count
    always_comb begin
        next_state = state;
        out_nxt    = out;
        rld_nxt    = rld;
        unique case (state)
            IDLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (load) begin
                    out_nxt = preset;
                    rld_nxt = preset;
                end else if (start) begin
                    out_nxt    = preset;
                    rld_nxt    = preset;
                    next_state = preset_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (load) begin
                    out_nxt    = preset;
                    rld_nxt    = preset;
                    next_state = preset_zero ? DONE : RUN;
                end else if (en) begin
                    if (out_le_one) begin
                        out_nxt    = ZERO;
                        next_state = DONE;
                    end else begin
                        out_nxt = out - ONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (auto_reload && !rld_zero) begin
                    out_nxt    = rld;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Count, reload value and registered Moore flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= ZERO;
            rld  <= ZERO;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            out  <= out_nxt;
            rld  <= rld_nxt;
            busy <= state_is_busy(next_state);
            done <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       load = 1'b0;
    logic       abort = 1'b0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [4:0] preset = 5'd0;
    logic [4:0] out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 = idle, 1 = counting, 2 = terminal cycle
    int m_phase = 0;
    int m_count = 0;
    int m_reload = 0;
    logic prev_done = 1'b0;

    countdown_timer #(.N(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load(load),
        .abort(abort),
        .en(en),
        .auto_reload(auto_reload),
        .preset(preset),
        .out(out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model advanced on every rising edge from the sampled inputs
    always @(posedge clk) begin
        int ph;
        int c;
        int r;
        ph = m_phase;
        c  = m_count;
        r  = m_reload;
        if (rst) begin
            ph = 0; c = 0; r = 0;
        end else if (m_phase == 0) begin
            if (abort) begin
                ph = 0;
            end else if (load) begin
                c = int'(preset); r = int'(preset);
            end else if (start) begin
                c = int'(preset); r = int'(preset);
                ph = (preset == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (abort) begin
                ph = 0;
            end else if (load) begin
                c = int'(preset); r = int'(preset);
                ph = (preset == 0) ? 2 : 1;
            end else if (en) begin
                c = c - 1;
                if (c == 0) ph = 2;
            end
        end else begin
            if (!abort && auto_reload && r != 0) begin
                c = r; ph = 1;
            end else begin
                ph = 0;
            end
        end
        m_phase  <= ph;
        m_count  <= c;
        m_reload <= r;
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        vectors = vectors + 1;
        if (int'(out) != m_count) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_out t=%0t got %0d expected %0d", $time, out, m_count);
        end
        vectors = vectors + 1;
        if (busy !== (m_phase != 0)) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_busy t=%0t got %b expected %b", $time, busy, m_phase != 0);
        end
        vectors = vectors + 1;
        if (done !== (m_phase == 2)) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL model_done t=%0t got %b expected %b", $time, done, m_phase == 2);
        end
        vectors = vectors + 1;
        if (done === 1'b1 && prev_done === 1'b1) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL done_twice t=%0t got 2 consecutive expected 1", $time);
        end
        prev_done = done;
    end

    task automatic applyStimulus(input logic r, input logic s, input logic l,
                                 input logic a, input logic e, input logic ar,
                                 input logic [4:0] p);
        rst = r; start = s; load = l; abort = a; en = e; auto_reload = ar; preset = p;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_out,
                               input logic exp_busy, input logic exp_done);
        vectors = vectors + 1;
        if (int'(out) != exp_out || busy !== exp_busy || done !== exp_done) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s got out=%0d busy=%b done=%b expected out=%0d busy=%b done=%b",
                     name, out, busy, done, exp_out, exp_busy, exp_done);
        end
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 5'd0);
        tick(2);
        checkOutput("reset", 0, 0, 0);
        rst = 0;

        // Basic count from 27
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd27);
        tick(1);
        start = 0;
        checkOutput("start27", 27, 1, 0);
        tick(26);
        checkOutput("count27_at1", 1, 1, 0);
        tick(1);
        checkOutput("done27", 0, 1, 1);
        tick(1);
        checkOutput("idle27", 0, 0, 0);

        // Reset held for 3 cycles mid-count
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd27);
        tick(1);
        start = 0;
        tick(5);
        checkOutput("midcount22", 22, 1, 0);
        rst = 1;
        tick(3);
        checkOutput("reset_mid", 0, 0, 0);
        rst = 0;

        // Pause for 4 cycles during a count from 10
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd10);
        tick(1);
        start = 0;
        tick(3);
        en = 0;
        tick(4);
        checkOutput("paused7", 7, 1, 0);
        en = 1;
        tick(6);
        checkOutput("pause_at1", 1, 1, 0);
        tick(1);
        checkOutput("pause_done", 0, 1, 1);
        tick(1);

        // Abort at out=6
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd10);
        tick(1);
        start = 0;
        tick(4);
        checkOutput("pre_abort6", 6, 1, 0);
        abort = 1;
        tick(1);
        abort = 0;
        checkOutput("abort6", 6, 0, 0);
        tick(3);
        checkOutput("abort_hold", 6, 0, 0);

        // Auto-reload from 3: done every 4 cycles
        applyStimulus(0, 1, 0, 0, 1, 1, 5'd3);
        tick(1);
        start = 0;
        tick(2);
        checkOutput("auto_at1", 1, 1, 0);
        tick(1);
        checkOutput("auto_done1", 0, 1, 1);
        tick(1);
        checkOutput("auto_reload3", 3, 1, 0);
        tick(3);
        checkOutput("auto_done2", 0, 1, 1);
        tick(1);
        checkOutput("auto_reload3b", 3, 1, 0);
        auto_reload = 0;
        tick(3);
        checkOutput("auto_done3", 0, 1, 1);
        tick(1);
        checkOutput("auto_stop", 0, 0, 0);

        // Start with preset 0 goes straight to the terminal cycle
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd0);
        tick(1);
        start = 0;
        checkOutput("zero_done", 0, 1, 1);
        tick(1);
        checkOutput("zero_idle", 0, 0, 0);

        // Load and start together in idle: load wins
        applyStimulus(0, 1, 1, 0, 1, 0, 5'd9);
        tick(1);
        start = 0; load = 0;
        checkOutput("load_wins", 9, 0, 0);

        // Load 20 during a run, count continues from there
        applyStimulus(0, 1, 0, 0, 1, 0, 5'd15);
        tick(1);
        start = 0;
        tick(1);
        checkOutput("run14", 14, 1, 0);
        preset = 5'd20; load = 1;
        tick(1);
        load = 0;
        checkOutput("load20", 20, 1, 0);
        tick(1);
        checkOutput("after_load19", 19, 1, 0);

        // Start during a run is ignored
        preset = 5'd5; start = 1;
        tick(1);
        start = 0;
        checkOutput("start_ignored", 18, 1, 0);
        abort = 1;
        tick(1);
        abort = 0;

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] p;
            if ($urandom_range(0, 99) < 30) p = 5'($urandom_range(0, 3));
            else p = 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 80,
                          $urandom_range(0, 99) < 50,
                          p);
            tick(1);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
